// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: counts pattern hits on a valid/ready bit
// stream, pulsing match per hit and done when the configured hit target is reached.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT_RST = (PAT_W == 4) ? PAT_W'(4'b1100) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic [CNT_W-1:0] target;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;

  logic [PAT_W-1:0] shifted;
  logic [FW:0]      fill_inc;
  logic             accept;
  logic             full;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;

  // Fill count saturates at the pattern length once the window is populated.
  function automatic logic [FW-1:0] sat_fill(input logic [FW:0] v);
    if (v >= (FW+1)'(PAT_W)) sat_fill = FW'(PAT_W);
    else                     sat_fill = v[FW-1:0];
  endfunction

  assign busy      = (state == RUN);
  assign bit_ready = (state == RUN) & ~abort;
  assign accept    = bit_valid & bit_ready;
  assign shifted   = {hist, bit_in};
  assign fill_inc  = {1'b0, fill} + 1'b1;
  assign full      = (fill_inc >= (FW+1)'(PAT_W));
  assign hit       = accept & full & (shifted == pattern);
  assign cnt_inc   = match_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pattern     <= PAT_RST;
      overlap     <= 1'b1;
      target      <= CNT_W'(1);
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      match       <= 1'b0;
      done        <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
            target  <= cfg_target;
          end
          // Start uses the configuration held before this edge.
          if (start) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            if (target != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            hist <= shifted[PAT_W-2:0];
            fill <= sat_fill(fill_inc);
            if (hit) begin
              match       <= 1'b1;
              match_count <= cnt_inc;
              if (!overlap) fill <= '0;
              if (cnt_inc == target) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with immediate-assertion checks.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [0:5] seq  = 6'b101010;
  logic [0:5] m_ov = 6'b000101;
  logic [0:5] d_ov = 6'b000001;
  logic [0:5] m_no = 6'b000100;
  logic [0:3] s1   = 4'b1100;

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start),
    .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .match(match), .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic configure(input logic [3:0] p, input logic ov, input logic [7:0] t);
    cfg_pattern = p;
    cfg_overlap = ov;
    cfg_target  = t;
    cfg_load    = 1'b1;
    step();
    cfg_load    = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_load = 0; cfg_pattern = 0; cfg_overlap = 0; cfg_target = 0;
    start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    #7;
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_count", match_count, 0);
    #1 rst = 1'b0;
    step();

    // 1: reset defaults detect 1100 once
    go();
    chk("t1_busy", busy, 1);
    chk("t1_ready", bit_ready, 1);
    for (int i = 0; i < 3; i++) begin
      send(s1[i]);
      chk("t1_nomatch", match, 0);
    end
    send(s1[3]);
    chk("t1_match", match, 1);
    chk("t1_done", done, 1);
    chk("t1_count", match_count, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_ready_done", bit_ready, 0);
    step();
    chk("t1_done_clr", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ready", bit_ready, 0);

    // 2: pattern 1010 overlapping, then non-overlapping
    configure(4'b1010, 1'b1, 8'd2);
    go();
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      chk("t2_ov_match", match, m_ov[i]);
      chk("t2_ov_done", done, d_ov[i]);
    end
    chk("t2_ov_count", match_count, 2);
    step();
    configure(4'b1010, 1'b0, 8'd2);
    go();
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      chk("t2_no_match", match, m_no[i]);
      chk("t2_no_done", done, 0);
    end
    chk("t2_no_count", match_count, 1);
    chk("t2_no_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t2_abort_busy", busy, 0);
    chk("t2_abort_count", match_count, 1);

    // 3: gaps between bits are transparent
    configure(4'b1100, 1'b1, 8'd1);
    go();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 3; g++) begin
        step();
        chk("t3_gap_ready", bit_ready, 1);
        chk("t3_gap_match", match, 0);
      end
      send(s1[i]);
    end
    chk("t3_match", match, 1);
    chk("t3_done", done, 1);
    chk("t3_count", match_count, 1);
    step();

    // 4: abort with a valid bit present consumes nothing
    go();
    send(1'b1); send(1'b1); send(1'b0);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    #1;
    chk("t4_ready_abort", bit_ready, 0);
    step();
    abort = 1'b0; bit_valid = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_match", match, 0);
    chk("t4_done", done, 0);
    chk("t4_count", match_count, 0);
    step();
    chk("t4_idle_ready", bit_ready, 0);

    // 5: zero target finishes immediately; config/start ignored in RUN
    configure(4'b1100, 1'b1, 8'd0);
    go();
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_count", match_count, 0);
    step();
    chk("t5_done_clr", done, 0);
    configure(4'b1100, 1'b1, 8'd1);
    go();
    cfg_pattern = 4'b0011; cfg_target = 8'd5; cfg_load = 1'b1; start = 1'b1;
    step();
    cfg_load = 1'b0; start = 1'b0;
    chk("t5_run_busy", busy, 1);
    for (int i = 0; i < 4; i++) send(s1[i]);
    chk("t5_run_match", match, 1);
    chk("t5_run_done", done, 1);
    chk("t5_run_count", match_count, 1);
    step();

    // 6: asynchronous reset mid-run
    configure(4'b1010, 1'b1, 8'd3);
    go();
    for (int i = 0; i < 4; i++) send(seq[i]);
    chk("t6_pre_match", match, 1);
    chk("t6_pre_count", match_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_match", match, 0);
    chk("t6_rst_count", match_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", bit_ready, 0);
    rst = 1'b0;
    step();
    go();
    for (int i = 0; i < 4; i++) send(s1[i]);
    chk("t6_dflt_match", match, 1);
    chk("t6_dflt_done", done, 1);
    chk("t6_dflt_count", match_count, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
